// File: rtl/sargantana_l15_responder.sv
// sargantana_l15_responder: L1.5-side responder servicing loads, instruction misses and stores against an internal word memory
module sargantana_l15_responder #(
    parameter int LatencyCycles = 4,
    parameter int MemWords      = 1024,
    parameter int QueueDepth    = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        l15_val_i,
    input  logic [4:0]  l15_req_type_i,
    input  logic        l15_nc_i,
    input  logic [2:0]  l15_size_i,
    input  logic        l15_threadid_i,
    input  logic [39:0] l15_address_i,
    input  logic [63:0] l15_data_i,
    output logic        l15_header_ack_o,
    output logic        l15_ack_o,
    output logic        l15_rtrn_val_o,
    input  logic        l15_req_ack_i,
    output logic [3:0]  l15_returntype_o,
    output logic [1:0]  l15_error_o,
    output logic        l15_rtrn_nc_o,
    output logic        l15_rtrn_threadid_o,
    output logic        l15_f4b_o,
    output logic [63:0] l15_data_0_o,
    output logic [63:0] l15_data_1_o,
    output logic [63:0] l15_data_2_o,
    output logic [63:0] l15_data_3_o
);
    localparam int AW = $clog2(MemWords);
    localparam int PW = $clog2(QueueDepth);

    typedef enum logic {IDLE, RESP} state_t;

    logic [63:0]   mem_q [MemWords];
    logic [3:0]    q_type_q [QueueDepth];
    logic [1:0]    q_err_q  [QueueDepth];
    logic          q_nc_q   [QueueDepth];
    logic          q_tid_q  [QueueDepth];
    logic [63:0]   q_dat_q  [QueueDepth][4];
    logic [7:0]    q_age_q  [QueueDepth];
    logic [PW-1:0] wr_q, rd_q;
    logic [PW:0]   cnt_q;
    state_t        state_q;
    logic          rtrn_val_q, rtrn_nc_q, rtrn_tid_q;
    logic [3:0]    rtrn_type_q;
    logic [1:0]    rtrn_err_q;
    logic [63:0]   rtrn_dat_q [4];

    logic [AW-1:0] idx;
    logic          is_ld, is_im, is_st, full, push, pop, head_rdy;
    logic [3:0]    nbytes, off;
    logic [7:0]    be;
    logic [3:0]    type_d;
    logic [1:0]    err_d;
    logic [63:0]   dat_d [4];
    logic          unused_addr;

    assign unused_addr      = ^l15_address_i[39:3+AW];
    assign full             = cnt_q == (PW+1)'(QueueDepth);
    assign l15_header_ack_o = l15_val_i & ~full & rst_ni;
    assign l15_ack_o        = l15_header_ack_o;
    assign push             = l15_header_ack_o;
    assign pop              = (state_q == RESP) & l15_req_ack_i;
    assign head_rdy         = (cnt_q != '0) && (q_age_q[rd_q] >= 8'(LatencyCycles - 1));

    // Decode the request and gather its response payload from memory at accept time
    always_comb begin
        idx    = l15_address_i[3 +: AW];
        is_ld  = l15_req_type_i == 5'b00000;
        is_im  = l15_req_type_i == 5'b10000;
        is_st  = l15_req_type_i == 5'b00001;
        nbytes = l15_size_i == 3'd0 ? 4'd1 : l15_size_i == 3'd1 ? 4'd2 : l15_size_i == 3'd2 ? 4'd4 : 4'd8;
        off    = {1'b0, l15_address_i[2:0]};
        for (int b = 0; b < 8; b++) be[b] = (4'(b) >= off) && (4'(b) < off + nbytes);
        type_d = is_im ? 4'b0001 : is_st ? 4'b0100 : 4'b0000;
        err_d  = (is_ld | is_im | is_st) ? 2'b00 : 2'b11;
        for (int k = 0; k < 4; k++) dat_d[k] = '0;
        if (is_ld) begin
            dat_d[0] = mem_q[idx & ~AW'(1)];
            dat_d[1] = mem_q[idx | AW'(1)];
        end
        if (is_im) for (int k = 0; k < 4; k++) dat_d[k] = mem_q[(idx & ~AW'(3)) + AW'(k)];
    end

    // Store bytes commit on the accept edge; contents survive reset
    always_ff @(posedge clk_i) begin
        if (push && is_st)
            for (int b = 0; b < 8; b++)
                if (be[b]) mem_q[idx][8*b +: 8] <= l15_data_i[8*b +: 8];
    end

    // Queue payload and per-entry saturating age; a pushed entry starts at age 0
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < QueueDepth; i++)
            q_age_q[i] <= q_age_q[i] >= 8'(LatencyCycles) ? 8'(LatencyCycles) : q_age_q[i] + 8'd1;
        if (push) begin
            q_type_q[wr_q] <= type_d;
            q_err_q[wr_q]  <= err_d;
            q_nc_q[wr_q]   <= l15_nc_i;
            q_tid_q[wr_q]  <= l15_threadid_i;
            q_age_q[wr_q]  <= '0;
            for (int k = 0; k < 4; k++) q_dat_q[wr_q][k] <= dat_d[k];
        end
    end

    // Queue pointers and occupancy
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_q + PW'(push);
            rd_q  <= rd_q + PW'(pop);
            cnt_q <= cnt_q + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    // Return FSM: present the aged head with registered outputs until the requester acks it
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            rtrn_val_q  <= 1'b0;
            rtrn_type_q <= '0;
            rtrn_err_q  <= '0;
            rtrn_nc_q   <= 1'b0;
            rtrn_tid_q  <= 1'b0;
            for (int k = 0; k < 4; k++) rtrn_dat_q[k] <= '0;
        end else if (state_q == IDLE && head_rdy) begin
            state_q     <= RESP;
            rtrn_val_q  <= 1'b1;
            rtrn_type_q <= q_type_q[rd_q];
            rtrn_err_q  <= q_err_q[rd_q];
            rtrn_nc_q   <= q_nc_q[rd_q];
            rtrn_tid_q  <= q_tid_q[rd_q];
            for (int k = 0; k < 4; k++) rtrn_dat_q[k] <= q_dat_q[rd_q][k];
        end else if (pop) begin
            state_q     <= IDLE;
            rtrn_val_q  <= 1'b0;
            rtrn_type_q <= '0;
            rtrn_err_q  <= '0;
            rtrn_nc_q   <= 1'b0;
            rtrn_tid_q  <= 1'b0;
            for (int k = 0; k < 4; k++) rtrn_dat_q[k] <= '0;
        end
    end

    assign l15_rtrn_val_o      = rtrn_val_q;
    assign l15_returntype_o    = rtrn_type_q;
    assign l15_error_o         = rtrn_err_q;
    assign l15_rtrn_nc_o       = rtrn_nc_q;
    assign l15_rtrn_threadid_o = rtrn_tid_q;
    assign l15_f4b_o           = 1'b0;
    assign l15_data_0_o        = rtrn_dat_q[0];
    assign l15_data_1_o        = rtrn_dat_q[1];
    assign l15_data_2_o        = rtrn_dat_q[2];
    assign l15_data_3_o        = rtrn_dat_q[3];
endmodule

// File: tb/tb_sargantana_l15_responder.sv
// tb_sargantana_l15_responder: directed self-checking bench for the L1.5 responder
module tb_sargantana_l15_responder;
    localparam logic [4:0] LD = 5'b00000, IM = 5'b10000, ST = 5'b00001, BAD = 5'b00110;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        val = 1'b0, nc = 1'b0, tid = 1'b0, req_ack = 1'b0;
    logic [4:0]  rtype = '0;
    logic [2:0]  size = '0;
    logic [39:0] addr = '0;
    logic [63:0] wdata = '0;
    logic        hack, ack, rval, rnc, rtid, f4b;
    logic [3:0]  rt;
    logic [1:0]  err;
    logic [63:0] d0, d1, d2, d3;
    int          n_cmp = 0, n_err = 0;
    int          lat;
    logic [63:0] bp_exp [5];

    always #5 clk = ~clk;

    sargantana_l15_responder dut (
        .clk_i(clk), .rst_ni(rst_n), .l15_val_i(val), .l15_req_type_i(rtype), .l15_nc_i(nc),
        .l15_size_i(size), .l15_threadid_i(tid), .l15_address_i(addr), .l15_data_i(wdata),
        .l15_header_ack_o(hack), .l15_ack_o(ack), .l15_rtrn_val_o(rval), .l15_req_ack_i(req_ack),
        .l15_returntype_o(rt), .l15_error_o(err), .l15_rtrn_nc_o(rnc), .l15_rtrn_threadid_o(rtid),
        .l15_f4b_o(f4b), .l15_data_0_o(d0), .l15_data_1_o(d1), .l15_data_2_o(d2), .l15_data_3_o(d3)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [4:0] t, input logic [2:0] s, input logic [39:0] a, input logic [63:0] d,
                         input logic n, input logic th);
        val = 1'b1; rtype = t; size = s; addr = a; wdata = d; nc = n; tid = th;
    endtask

    task automatic issue(input logic [4:0] t, input logic [2:0] s, input logic [39:0] a, input logic [63:0] d,
                         input logic n, input logic th);
        int w = 0;
        drive(t, s, a, d, n, th);
        #1;
        while (!hack && w < 50) begin
            @(negedge clk); #1; w++;
        end
        chk("accept", 64'(hack), 64'd1);
        chk("ack", 64'(ack), 64'd1);
        @(posedge clk);
        @(negedge clk);
        val = 1'b0;
    endtask

    task automatic get_rsp(output int l);
        l = 0;
        while (!rval && l < 50) begin
            @(negedge clk); l++;
        end
        chk("rtrn_val", 64'(rval), 64'd1);
    endtask

    task automatic take();
        req_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_ack = 1'b0;
        chk("val_drop", 64'(rval), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) dut.mem_q[i] = 64'hA5A5_0000_0000_0000 | 64'(i);
        dut.mem_q[2] = 64'h1111;
        dut.mem_q[3] = 64'h2222;
        val = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_hack", 64'(hack), 64'd0);
        chk("rst_ack", 64'(ack), 64'd0);
        chk("rst_val", 64'(rval), 64'd0);
        chk("rst_type", 64'(rt), 64'd0);
        chk("rst_d0", d0, 64'd0);
        val = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        issue(LD, 3'd3, 40'h18, 64'd0, 1'b1, 1'b1);
        get_rsp(lat);
        chk("ld_lat", 64'(lat), 64'd4);
        chk("ld_type", 64'(rt), 64'd0);
        chk("ld_err", 64'(err), 64'd0);
        chk("ld_d0", d0, 64'h1111);
        chk("ld_d1", d1, 64'h2222);
        chk("ld_d2", d2, 64'd0);
        chk("ld_d3", d3, 64'd0);
        chk("ld_nc", 64'(rnc), 64'd1);
        chk("ld_tid", 64'(rtid), 64'd1);
        chk("ld_f4b", 64'(f4b), 64'd0);
        repeat (2) @(negedge clk);
        chk("ld_hold", d0, 64'h1111);
        take();

        issue(ST, 3'd1, 40'h13, 64'h0000_00AA_BB00_0000, 1'b0, 1'b0);
        get_rsp(lat);
        chk("st_type", 64'(rt), 64'd4);
        chk("st_d0", d0, 64'd0);
        take();
        issue(ST, 3'd2, 40'h1E, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b0);
        get_rsp(lat);
        take();
        issue(LD, 3'd3, 40'h10, 64'd0, 1'b0, 1'b0);
        get_rsp(lat);
        chk("stld_d0", d0, 64'h0000_00AA_BB00_1111);
        chk("sttrunc_d1", d1, 64'h1234_0000_0000_2222);
        chk("stld_tid", 64'(rtid), 64'd0);
        take();

        issue(IM, 3'd3, 40'h27, 64'd0, 1'b0, 1'b1);
        get_rsp(lat);
        chk("im_type", 64'(rt), 64'd1);
        chk("im_d0", d0, 64'hA5A5_0000_0000_0004);
        chk("im_d1", d1, 64'hA5A5_0000_0000_0005);
        chk("im_d2", d2, 64'hA5A5_0000_0000_0006);
        chk("im_d3", d3, 64'hA5A5_0000_0000_0007);
        take();

        issue(BAD, 3'd3, 40'h10, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        get_rsp(lat);
        chk("bad_type", 64'(rt), 64'd0);
        chk("bad_err", 64'(err), 64'd3);
        chk("bad_d0", d0, 64'd0);
        chk("bad_d1", d1, 64'd0);
        take();
        issue(LD, 3'd0, 40'h10, 64'd0, 1'b0, 1'b0);
        get_rsp(lat);
        chk("bad_mem", d0, 64'h0000_00AA_BB00_1111);
        chk("bad_err_ok", 64'(err), 64'd0);
        take();

        bp_exp[0] = 64'h0000_00AA_BB00_1111;
        bp_exp[1] = 64'hA5A5_0000_0000_0004;
        bp_exp[2] = 64'hA5A5_0000_0000_0006;
        bp_exp[3] = 64'hA5A5_0000_0000_0008;
        bp_exp[4] = 64'hA5A5_0000_0000_000A;
        for (int i = 0; i < 4; i++) begin
            drive(LD, 3'd3, 40'(i * 16), 64'd0, 1'b0, 1'b0);
            #1;
            chk("bp_accept", 64'(hack), 64'd1);
            @(posedge clk);
            @(negedge clk);
        end
        drive(LD, 3'd3, 40'h40, 64'd0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("bp_stall", 64'(hack), 64'd0);
            @(negedge clk);
        end
        get_rsp(lat);
        chk("bp_first", d0, 64'hA5A5_0000_0000_0000);
        req_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_ack = 1'b0;
        #1;
        chk("bp_reopen", 64'(hack), 64'd1);
        @(posedge clk);
        @(negedge clk);
        drive(LD, 3'd3, 40'h50, 64'd0, 1'b0, 1'b0);
        #1;
        chk("bp_full6", 64'(hack), 64'd0);
        for (int j = 0; j < 5; j++) begin
            get_rsp(lat);
            if (j >= 2) chk("b2b_gap", 64'(lat), 64'd1);
            chk("bp_order", d0, bp_exp[j]);
            take();
            if (j == 0) begin
                #1;
                chk("bp_acc6", 64'(hack), 64'd1);
                @(posedge clk);
                @(negedge clk);
                val = 1'b0;
            end
        end

        issue(LD, 3'd3, 40'h00, 64'd0, 1'b1, 1'b1);
        get_rsp(lat);
        val = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("mid_val", 64'(rval), 64'd0);
        chk("mid_type", 64'(rt), 64'd0);
        chk("mid_d0", d0, 64'd0);
        chk("mid_nc", 64'(rnc), 64'd0);
        chk("mid_hack", 64'(hack), 64'd0);
        @(negedge clk);
        val = 1'b0;
        rst_n = 1'b1;
        begin
            logic seen = 1'b0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                seen |= rval;
            end
            chk("mid_empty", 64'(seen), 64'd0);
        end
        issue(LD, 3'd3, 40'h18, 64'd0, 1'b0, 1'b0);
        get_rsp(lat);
        chk("post_lat", 64'(lat), 64'd4);
        chk("post_d0", d0, 64'h0000_00AA_BB00_1111);
        chk("post_d1", d1, 64'h1234_0000_0000_2222);
        take();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
